// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns
// (index 0 = segment a, 0 = lit), digit-enable codes and the scan FSM states.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_HRS_TENS  = 4'b0111;
  localparam logic [3:0] AN_HRS_ONES  = 4'b1011;
  localparam logic [3:0] AN_MINS_TENS = 4'b1101;
  localparam logic [3:0] AN_MINS_ONES = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

  // Returns {valid, digit index}; index 3 = hrs_tens ... 0 = mins_ones.
  function automatic logic [2:0] an_decode(input logic [3:0] an);
    logic [2:0] res;
    res = 3'b000;
    case (an)
      AN_HRS_TENS:  res = 3'b111;
      AN_HRS_ONES:  res = 3'b110;
      AN_MINS_TENS: res = 3'b101;
      AN_MINS_ONES: res = 3'b100;
      default:      res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decoder; anything outside the
// ten digit patterns (blank included) reports 4'hF with invalid set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = 4'hF;
    invalid = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit   = 4'hF;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers four BCD digits from a multiplexed seven-segment display scan and
// publishes them as one atomic frame once every digit has been captured.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no digit enabled, waiting for a valid an code
// ST_SETTLE  | counting consecutive cycles with seg/an unchanged
// ST_CAPTURE | one cycle: write shadow entry, set mask bit, clear timeout
// ST_HOLD    | digit taken, waiting for an to move on
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] seg,
  input  logic [3:0] an,
  output logic [3:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       stale
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [15:0]   SET_MAX = 16'(SETTLE - 1);

  logic [0:6]    seg_q, seg_p;
  logic [3:0]    an_q, an_p;
  scan_state_t   state;
  logic [15:0]   set_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    mask;
  logic [3:0]    shadow_val [4];
  logic [3:0]    shadow_err;
  logic [3:0]    cap_val;
  logic          cap_err;
  logic [1:0]    cap_idx;
  logic [3:0]    cap_an;

  logic [2:0]    an_info;
  logic          an_ok;
  logic [1:0]    an_idx;
  logic          changed;
  logic [3:0]    dec_val;
  logic          dec_bad;
  logic          commit;
  logic          timeout_hit;

  seg7_decode u_decode (
    .seg     (seg_q),
    .digit   (dec_val),
    .invalid (dec_bad)
  );

  assign an_info     = an_decode(an_q);
  assign an_ok       = an_info[2];
  assign an_idx      = an_info[1:0];
  assign changed     = (seg_q != seg_p) || (an_q != an_p);
  assign commit      = (mask == 4'hF);
  assign timeout_hit = (to_cnt == TO_MAX);

  // seg_p/an_p hold the previous registered sample for the stability check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= '0;
      seg_p <= '0;
      an_q  <= 4'hF;
      an_p  <= 4'hF;
    end else begin
      seg_q <= seg;
      seg_p <= seg_q;
      an_q  <= an;
      an_p  <= an_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      set_cnt     <= '0;
      to_cnt      <= '0;
      mask        <= '0;
      shadow_val  <= '{default: 4'h0};
      shadow_err  <= '0;
      cap_val     <= '0;
      cap_err     <= 1'b0;
      cap_idx     <= '0;
      cap_an      <= 4'hF;
      hrs_tens    <= '0;
      hrs_ones    <= '0;
      mins_tens   <= '0;
      mins_ones   <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (an_ok) begin
            state   <= ST_SETTLE;
            set_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (!an_ok) begin
            state <= ST_IDLE;
          end else if (changed) begin
            set_cnt <= '0;
          end else if (set_cnt == SET_MAX) begin
            state   <= ST_CAPTURE;
            cap_val <= dec_val;
            cap_err <= dec_bad;
            cap_idx <= an_idx;
            cap_an  <= an_q;
          end else begin
            set_cnt <= set_cnt + 16'd1;
          end
        end
        ST_CAPTURE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Compared against the captured code so a move during CAPTURE is not missed.
          if (an_q != cap_an) begin
            if (an_ok) begin
              state   <= ST_SETTLE;
              set_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (state == ST_CAPTURE) begin
        shadow_val[cap_idx] <= cap_val;
        shadow_err[cap_idx] <= cap_err;
        mask[cap_idx]       <= 1'b1;
        to_cnt              <= '0;
      end else begin
        if (!timeout_hit) to_cnt <= to_cnt + 1'b1;
        // A completing frame takes priority over a coincident timeout.
        if (commit) begin
          hrs_tens    <= shadow_val[3];
          hrs_ones    <= shadow_val[2];
          mins_tens   <= shadow_val[1];
          mins_ones   <= shadow_val[0];
          digit_err   <= shadow_err;
          frame_valid <= 1'b1;
          mask        <= '0;
          stale       <= 1'b0;
        end else if (timeout_hit) begin
          stale <= 1'b1;
          mask  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a table of full scan frames plus
// hand-written sequences for settling, overwrite, staleness and reset.
module tb_seg_scan_decoder;
  import seg7_pkg::*;

  localparam logic [0:6] P0 = 7'b0000001;
  localparam logic [0:6] P1 = 7'b1001111;
  localparam logic [0:6] P2 = 7'b0010010;
  localparam logic [0:6] P3 = 7'b0000110;
  localparam logic [0:6] P4 = 7'b1001100;
  localparam logic [0:6] P5 = 7'b0100100;
  localparam logic [0:6] P6 = 7'b0100000;
  localparam logic [0:6] P7 = 7'b0001111;
  localparam logic [0:6] P8 = 7'b0000000;
  localparam logic [0:6] P9 = 7'b0000100;
  localparam logic [0:6] PB = 7'b1111111;
  localparam logic [0:6] PX = 7'b1111110;
  localparam logic [0:6] PY = 7'b0110000;

  localparam logic [3:0] A_HT = 4'b0111;
  localparam logic [3:0] A_HO = 4'b1011;
  localparam logic [3:0] A_MT = 4'b1101;
  localparam logic [3:0] A_MO = 4'b1110;
  localparam logic [3:0] A_NONE = 4'b1111;

  localparam int DWELL = 30;

  logic       clk;
  logic       rst;
  logic [0:6] seg;
  logic [3:0] an;
  logic [3:0] hrs_tens, hrs_ones, mins_tens, mins_ones;
  logic [3:0] digit_err;
  logic       frame_valid;
  logic       stale;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt  = 0;

  seg_scan_decoder #(.SETTLE(16), .TIMEOUT(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .hrs_tens    (hrs_tens),
    .hrs_ones    (hrs_ones),
    .mins_tens   (mins_tens),
    .mins_ones   (mins_ones),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:6]  s [4];
    logic [15:0] val;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic show(input logic [3:0] a, input logic [0:6] s, input int n);
    an  = a;
    seg = s;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid) fv_cnt++;
    end
  endtask

  function automatic logic [15:0] outs();
    return {hrs_tens, hrs_ones, mins_tens, mins_ones};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;

    vecs[0].s = '{P1, P2, P3, P4}; vecs[0].val = 16'h1234; vecs[0].err = 4'b0000;
    vecs[1].s = '{P0, P5, P6, PB}; vecs[1].val = 16'h056F; vecs[1].err = 4'b0001;
    vecs[2].s = '{P7, P8, P9, P0}; vecs[2].val = 16'h7890; vecs[2].err = 4'b0000;
    vecs[3].s = '{PX, P9, PY, P3}; vecs[3].val = 16'hF9F3; vecs[3].err = 4'b1010;

    rst = 1'b0;
    seg = PB;
    an  = A_NONE;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_err", 32'(digit_err), 32'h0);
    check("reset_fv_stale", 32'({frame_valid, stale}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Full frames in scan order hrs_tens .. mins_ones
    prev = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      fv_cnt = 0;
      show(A_HT, vecs[i].s[0], DWELL);
      show(A_HO, vecs[i].s[1], DWELL);
      show(A_MT, vecs[i].s[2], DWELL);
      check($sformatf("v%0d_partial_fv", i), 32'(fv_cnt), 32'd0);
      check($sformatf("v%0d_partial_hold", i), 32'(outs()), 32'(prev));
      show(A_MO, vecs[i].s[3], DWELL);
      check($sformatf("v%0d_fv", i), 32'(fv_cnt), 32'd1);
      check($sformatf("v%0d_val", i), 32'(outs()), 32'(vecs[i].val));
      check($sformatf("v%0d_err", i), 32'(digit_err), 32'(vecs[i].err));
      check($sformatf("v%0d_stale", i), 32'(stale), 32'd0);
      prev = vecs[i].val;
    end

    // seg toggling faster than the settle window never captures hrs_ones
    fv_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      show(A_HO, (k % 2 == 1) ? P1 : P7, 8);
      if (k == 6) check("toggle_state_mid", 32'(dut.state), 32'(ST_SETTLE));
    end
    check("toggle_state_end", 32'(dut.state), 32'(ST_SETTLE));
    show(A_HT, P2, DWELL);
    show(A_MT, P5, DWELL);
    show(A_MO, P6, DWELL);
    check("toggle_no_fv", 32'(fv_cnt), 32'd0);
    check("toggle_outs_hold", 32'(outs()), 32'hF9F3);
    show(A_HO, P3, DWELL);
    check("toggle_fv", 32'(fv_cnt), 32'd1);
    check("toggle_val", 32'(outs()), 32'h2356);

    // Re-captured hrs_tens overwrites its shadow entry
    fv_cnt = 0;
    show(A_HT, P5, DWELL);
    show(A_HO, P1, DWELL);
    show(A_HT, P7, DWELL);
    show(A_MT, P2, DWELL);
    show(A_MO, P3, DWELL);
    check("overwrite_fv", 32'(fv_cnt), 32'd1);
    check("overwrite_val", 32'(outs()), 32'h7123);
    check("overwrite_err", 32'(digit_err), 32'h0);

    // Timeout after a partial frame discards it and raises stale
    fv_cnt = 0;
    show(A_HT, P9, DWELL);
    show(A_HO, P8, DWELL);
    show(A_MT, P4, DWELL);
    check("pre_stale", 32'(stale), 32'd0);
    show(A_NONE, P8, 250);
    check("stale_set", 32'(stale), 32'd1);
    check("stale_outs_hold", 32'(outs()), 32'h7123);
    show(A_MO, P6, DWELL);
    check("stale_mask_cleared", 32'(fv_cnt), 32'd0);
    show(A_HT, P1, DWELL);
    show(A_HO, P0, DWELL);
    show(A_MT, P2, DWELL);
    check("stale_recover_fv", 32'(fv_cnt), 32'd1);
    check("stale_recover_val", 32'(outs()), 32'h1026);
    check("stale_cleared", 32'(stale), 32'd0);

    // Reset in the middle of hrs_ones settling
    fv_cnt = 0;
    show(A_HT, P4, DWELL);
    show(A_HO, P5, 8);
    rst = 1'b0;
    #1;
    check("midrst_outs", 32'(outs()), 32'h0);
    check("midrst_err_fv_stale", 32'({digit_err, frame_valid, stale}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    show(A_HO, P5, 10);
    check("postrst_still_settling", 32'(dut.state), 32'(ST_SETTLE));
    show(A_HO, P5, 20);
    show(A_MT, P6, DWELL);
    show(A_MO, P7, DWELL);
    check("postrst_no_fv", 32'(fv_cnt), 32'd0);
    show(A_HT, P8, DWELL);
    check("postrst_fv", 32'(fv_cnt), 32'd1);
    check("postrst_val", 32'(outs()), 32'h8567);
    check("postrst_err", 32'(digit_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 16: cycles seg/an must stay stable before a digit is sampled (range 1..65535).
REQ-002 Parameter TIMEOUT, default 400000: cycles without a valid digit capture before the stale flag is raised.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 seg  input  [0:6]  multiplexed segment lines; seg[0]=a … seg[6]=g; 0 = lit.
REQ-006 an  input  [3:0]  digit enables; active-low one-hot.
REQ-007 hrs_tens, hrs_ones, mins_tens, mins_ones  output  4 each  decoded BCD digits; registered.
REQ-008 digit_err  output  4  per-digit invalid-pattern flag; bit3=hrs_tens … bit0=mins_ones; registered.
REQ-009 frame_valid  output  1  one-cycle pulse when a complete four-digit frame is committed.
REQ-010 stale  output  1  level; no capture within TIMEOUT cycles.

Function
REQ-011 an mapping SHALL be: 0111→hrs_tens, 1011→hrs_ones, 1101→mins_tens, 1110→mins_ones; any other an value is "no digit".
REQ-012 Pattern table (seg[0:6]) SHALL be: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-013 Any other seg pattern, including 1111111 (blank), SHALL decode to 4'hF with the digit's error bit set.
REQ-014 seg and an SHALL be registered once on input; all decisions use the registered copy (first-stage latency: 1 cycle).
REQ-015 FSM states: IDLE, SETTLE, CAPTURE, HOLD.
REQ-016 IDLE: an is "no digit" → stay; valid an → SETTLE, stability counter cleared.
REQ-017 SETTLE: counter increments each cycle seg and an equal their previous-cycle values; any change clears the counter; an becoming "no digit" → IDLE.
REQ-018 SETTLE → CAPTURE when counter reaches SETTLE-1 with inputs still unchanged.
REQ-019 CAPTURE (exactly one cycle): decoded value and error bit written to that digit's shadow register; digit's bit set in the captured mask; TIMEOUT counter cleared; → HOLD.
REQ-020 HOLD: wait until an changes; new valid an → SETTLE; "no digit" → IDLE; seg change alone does not recapture.
REQ-021 A digit captured again before the frame completes SHALL overwrite its shadow entry; mask unchanged.
REQ-022 When the mask becomes 4'b1111, the cycle after CAPTURE SHALL copy all four shadows and error bits to the outputs atomically, pulse frame_valid, clear the mask, and clear stale.
REQ-023 Outputs SHALL change only on frame commit; partial frames never appear on outputs.
REQ-024 TIMEOUT counter increments every cycle outside CAPTURE and saturates; on reaching TIMEOUT, stale=1 and the captured mask is cleared (partial frame discarded).
REQ-025 If frame commit and timeout coincide, commit wins; stale stays 0.

Reset
REQ-026 On rst=0: state IDLE; all counters, mask, shadows cleared; digit outputs 4'h0; digit_err 4'b0000; frame_valid 0; stale 0.
REQ-027 Reset asserted mid-SETTLE or mid-frame SHALL discard all partial capture; no frame_valid is issued for it.
REQ-028 After rst deassertion, first capture requires a full SETTLE window.

Structure
REQ-029 Shared package seg7_pkg SHALL hold the ten segment pattern constants, the blank pattern, the four an codes, and the FSM state enum.
REQ-030 Combinational sub-module seg7_decode (seg → 4-bit BCD + invalid) SHALL be instantiated once.

Verification
REQ-031 Scan digits 1,2,3,4 (an 0111..1110), 100000 cycles each, SETTLE=16 → one frame_valid after fourth capture; outputs 1,2,3,4; digit_err 0000.
REQ-032 seg toggles every 8 cycles with SETTLE=16 while an=1011 → no capture; state cycles SETTLE; no frame_valid.
REQ-033 mins_ones shows 1111111 in an otherwise valid frame → mins_ones=4'hF, digit_err=4'b0001, frame_valid pulses.
REQ-034 an held at 1111 for 400000 cycles after three captures → stale=1, mask cleared; next four full captures → frame_valid, stale=0.
REQ-035 rst pulsed low during hrs_ones SETTLE → all outputs 0 immediately; following full scan yields correct frame.
REQ-036 hrs_tens captured as 5 then 7 before frame completes → committed hrs_tens=7, single frame_valid.
